// File: rtl/pong_pkg.sv
// Shared pong definitions: ball FSM states, screen geometry and coordinate type.
package pong_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    typedef enum logic [2:0] {
        SERVE,
        TICK,
        WAIT_DRAW,
        MOVE,
        SCORE
    } state_t;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
    } coord_t;

endpackage

// File: rtl/step_timer.sv
// Movement step timer: counts cycles while enabled and flags the last cycle of a step period.
module step_timer #(
    parameter int TICK_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TICK_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == LAST);

    // Next count: restart on clear or at the end of a period, otherwise advance when enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clear || expired) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ball_motion.sv
// Pong ball motion: owns ball position/direction, bounces off walls and paddles,
// and pulses a score when the ball reaches a side edge. Steps only when the
// timer has expired and the drawer is idle.
module ball_motion
    import pong_pkg::*;
#(
    parameter int RADIUS      = 4,
    parameter int TICK_CYCLES = 500000,
    parameter int SCR_W       = SCREEN_W,
    parameter int SCR_H       = SCREEN_H,
    parameter int PADDLE_LEN  = 16,
    parameter int PADDLE_XL   = 4,
    parameter int PADDLE_XR   = 155
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] paddle_l_y,
    input  logic [6:0] paddle_r_y,
    input  logic       draw_done,
    output logic [7:0] ball_x,
    output logic [6:0] ball_y,
    output logic       in_play,
    output logic       score_l,
    output logic       score_r
);

    // Centre-coordinate thresholds; the radius is folded in so no subtraction is needed.
    localparam logic [7:0] X_CENTRE = 8'(SCR_W / 2);
    localparam logic [6:0] Y_CENTRE = 7'(SCR_H / 2);
    localparam logic [7:0] X_PAD_L  = 8'(PADDLE_XL + 1 + RADIUS);
    localparam logic [7:0] X_PAD_R  = 8'(PADDLE_XR - 1 - RADIUS);
    localparam logic [7:0] X_EDGE_L = 8'(RADIUS);
    localparam logic [7:0] X_EDGE_R = 8'(SCR_W - 1 - RADIUS);
    localparam logic [6:0] Y_TOP    = 7'(RADIUS);
    localparam logic [6:0] Y_BOT    = 7'(SCR_H - 1 - RADIUS);
    localparam logic [7:0] PAD_SPAN = 8'(PADDLE_LEN - 1);

    state_t state_q, state_d;
    coord_t pos_q, pos_d;
    logic   dx_neg_q, dx_neg_d;
    logic   dy_neg_q, dy_neg_d;
    logic   score_l_q, score_l_d;
    logic   score_r_q, score_r_d;
    logic   in_play_q, in_play_d;

    logic   tick_clr, tick_en, tick_expired;
    logic   in_win_l, in_win_r;
    logic   hit_l, hit_r, miss_l, miss_r;

    step_timer #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_step_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (tick_clr),
        .en     (tick_en),
        .expired(tick_expired)
    );

    assign tick_en  = (state_q == TICK);
    assign tick_clr = (state_q != TICK);

    // Paddle windows compared in 8 bits so paddle_y + PADDLE_LEN - 1 cannot wrap.
    assign in_win_l = ({1'b0, paddle_l_y} <= {1'b0, pos_q.y}) &&
                      ({1'b0, pos_q.y} <= ({1'b0, paddle_l_y} + PAD_SPAN));
    assign in_win_r = ({1'b0, paddle_r_y} <= {1'b0, pos_q.y}) &&
                      ({1'b0, pos_q.y} <= ({1'b0, paddle_r_y} + PAD_SPAN));

    assign hit_l  =  dx_neg_q && (pos_q.x == X_PAD_L) && in_win_l;
    assign hit_r  = !dx_neg_q && (pos_q.x == X_PAD_R) && in_win_r;
    assign miss_l =  dx_neg_q && (pos_q.x == X_EDGE_L);
    assign miss_r = !dx_neg_q && (pos_q.x == X_EDGE_R);

    // Next-state, motion and collision logic.
    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        dx_neg_d  = dx_neg_q;
        dy_neg_d  = dy_neg_q;
        score_l_d = 1'b0;
        score_r_d = 1'b0;

        case (state_q)
            SERVE: begin
                if (start) begin
                    state_d = TICK;
                end
            end
            TICK: begin
                if (tick_expired) begin
                    state_d = WAIT_DRAW;
                end
            end
            WAIT_DRAW: begin
                if (draw_done) begin
                    state_d = MOVE;
                end
            end
            MOVE: begin
                if (miss_l || miss_r) begin
                    // Position is frozen on a scoring step; the serve recentres it.
                    score_r_d = miss_l;
                    score_l_d = miss_r;
                    state_d   = SCORE;
                end else begin
                    state_d = TICK;
                    if (hit_l) begin
                        dx_neg_d = 1'b0;
                        pos_d.x  = pos_q.x + 8'd1;
                    end else if (hit_r) begin
                        dx_neg_d = 1'b1;
                        pos_d.x  = pos_q.x - 8'd1;
                    end else begin
                        pos_d.x = dx_neg_q ? pos_q.x - 8'd1 : pos_q.x + 8'd1;
                    end

                    if (!dy_neg_q && (pos_q.y >= Y_BOT)) begin
                        dy_neg_d = 1'b1;
                        pos_d.y  = pos_q.y - 7'd1;
                    end else if (dy_neg_q && (pos_q.y <= Y_TOP)) begin
                        dy_neg_d = 1'b0;
                        pos_d.y  = pos_q.y + 7'd1;
                    end else begin
                        pos_d.y = dy_neg_q ? pos_q.y - 7'd1 : pos_q.y + 7'd1;
                    end
                end
            end
            SCORE: begin
                // Serve heads toward the player who just scored.
                pos_d.x  = X_CENTRE;
                pos_d.y  = Y_CENTRE;
                dx_neg_d = ~dx_neg_q;
                dy_neg_d = 1'b0;
                state_d  = SERVE;
            end
            default: begin
                state_d = SERVE;
            end
        endcase

        in_play_d = (state_d == TICK) || (state_d == WAIT_DRAW) || (state_d == MOVE);
    end

    // State, position, direction and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= SERVE;
            pos_q.x   <= X_CENTRE;
            pos_q.y   <= Y_CENTRE;
            dx_neg_q  <= 1'b0;
            dy_neg_q  <= 1'b0;
            score_l_q <= 1'b0;
            score_r_q <= 1'b0;
            in_play_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            dx_neg_q  <= dx_neg_d;
            dy_neg_q  <= dy_neg_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            in_play_q <= in_play_d;
        end
    end

    assign ball_x  = pos_q.x;
    assign ball_y  = pos_q.y;
    assign in_play = in_play_q;
    assign score_l = score_l_q;
    assign score_r = score_r_q;

endmodule
